// File: rtl/irq_arbiter_pkg.sv
// Shared constants for the CPU-side interrupt arbiter.
package irq_arbiter_pkg;

  // Lattuino mapping: INT0=1, INT1=2, devices 3..5; vector 0 is reset.
  localparam int unsigned IrqLinesDefault  = 5;
  localparam int unsigned VecWDefault      = 5;
  localparam int unsigned VecOffsetDefault = 1;

  typedef enum logic [1:0] {
    IrqaIdle = 2'd0,
    IrqaReq  = 2'd1,
    IrqaAck  = 2'd2,
    IrqaHold = 2'd3
  } irqa_state_e;

endpackage

// File: rtl/irq_arbiter_if.sv
// Interrupt controller / core-fetch signals seen by the arbiter.
interface irq_arbiter_if #(
  parameter int unsigned IrqLines = 5,
  parameter int unsigned VecW     = 5
);
  logic [IrqLines-1:0] irq_lines;
  logic                i_flag;
  logic                inst_boundary;
  logic                sei_exec;
  logic                irq_take;
  logic                irq_req;
  logic [VecW-1:0]     irq_vector;
  logic [IrqLines-1:0] irq_ack;
  logic                pending;

  // Controller and core side.
  modport master (
    output irq_lines, i_flag, inst_boundary, sei_exec, irq_take,
    input  irq_req, irq_vector, irq_ack, pending
  );

  // Arbiter side.
  modport slave (
    input  irq_lines, i_flag, inst_boundary, sei_exec, irq_take,
    output irq_req, irq_vector, irq_ack, pending
  );
endinterface

// File: rtl/irq_arbiter_prio_enc.sv
// Lowest-index-wins priority encoder.
module irq_prio_enc #(
  parameter int unsigned Width = 5,
  parameter int unsigned IdxW  = (Width > 1) ? $clog2(Width) : 1
) (
  input  logic [Width-1:0] req_i,
  output logic [IdxW-1:0]  idx_o,
  output logic             valid_o
);

  // Scan from the top so the lowest set index is written last and wins.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = Width - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_arbiter.sv
// Samples interrupt lines at instruction boundaries, presents a stable vector
// to the core and acknowledges the serviced line once the vector is taken.
module irq_arbiter
  import irq_arbiter_pkg::*;
#(
  parameter int unsigned IrqLines  = IrqLinesDefault,
  parameter int unsigned VecW      = VecWDefault,
  parameter int unsigned VecOffset = VecOffsetDefault
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ena_i,
  irq_arbiter_if.slave irq_io
);

  localparam int unsigned IdxW = (IrqLines > 1) ? $clog2(IrqLines) : 1;

  irqa_state_e         state_q;
  logic [IdxW-1:0]     win_q;
  logic [IdxW-1:0]     enc_idx;
  logic                enc_valid;
  logic                req_q;
  logic                shadow_q;
  logic [VecW-1:0]     vec_q;
  logic [VecW-1:0]     vec_d;
  logic [IrqLines-1:0] ack_q;
  logic [IrqLines-1:0] win_onehot;
  logic                qualify;
  logic                win_line;

  irq_prio_enc #(
    .Width (IrqLines),
    .IdxW  (IdxW)
  ) u_prio_enc (
    .req_i   (irq_io.irq_lines),
    .idx_o   (enc_idx),
    .valid_o (enc_valid)
  );

  // A coinciding SEI/RETI also suppresses arbitration in that same cycle.
  assign qualify = irq_io.inst_boundary & irq_io.i_flag & ~shadow_q &
                   ~irq_io.sei_exec & enc_valid;

  assign vec_d      = VecW'(VecOffset + 32'(enc_idx));
  assign win_onehot = IrqLines'(1) << win_q;
  assign win_line   = irq_io.irq_lines[win_q];

  // Arbitration FSM with registered request, vector, ack and SEI shadow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IrqaIdle;
      win_q    <= '0;
      req_q    <= 1'b0;
      vec_q    <= '0;
      ack_q    <= '0;
      shadow_q <= 1'b0;
    end else if (ena_i) begin
      ack_q <= '0;
      if (irq_io.sei_exec) begin
        shadow_q <= 1'b1;
      end else if (irq_io.inst_boundary) begin
        shadow_q <= 1'b0;
      end
      unique case (state_q)
        IrqaIdle: begin
          if (qualify) begin
            win_q   <= enc_idx;
            vec_q   <= vec_d;
            req_q   <= 1'b1;
            state_q <= IrqaReq;
          end
        end
        IrqaReq: begin
          // Take wins over a same-cycle withdrawal.
          if (irq_io.irq_take) begin
            req_q   <= 1'b0;
            ack_q   <= win_onehot;
            state_q <= IrqaAck;
          end else if (!irq_io.i_flag || !win_line) begin
            req_q   <= 1'b0;
            state_q <= IrqaIdle;
          end
        end
        IrqaAck: begin
          state_q <= IrqaHold;
        end
        IrqaHold: begin
          if (!irq_io.i_flag || irq_io.sei_exec) begin
            state_q <= IrqaIdle;
          end
        end
        default: state_q <= IrqaIdle;
      endcase
    end
  end

  // Ack spans exactly one enabled cycle.
  always_comb begin
    irq_io.irq_ack = ena_i ? ack_q : '0;
  end

  assign irq_io.irq_req    = req_q;
  assign irq_io.irq_vector = vec_q;
  assign irq_io.pending    = (|irq_io.irq_lines) & irq_io.i_flag;

endmodule

// File: tb/tb_irq_arbiter.sv
// Scoreboard bench for irq_arbiter: directed scenarios then random traffic.
module tb_irq_arbiter;

  localparam int unsigned NL = 5;
  localparam int unsigned VW = 5;

  logic clk;
  logic rst;
  logic ena;

  irq_arbiter_if #(.IrqLines(NL), .VecW(VW)) bus ();

  irq_arbiter #(
    .IrqLines  (NL),
    .VecW      (VW),
    .VecOffset (1)
  ) u_dut (
    .clk_i  (clk),
    .rst_i  (rst),
    .ena_i  (ena),
    .irq_io (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic        req;
    logic [4:0]  vec;
    logic [4:0]  ack;
    logic        pend;
    bit          chk_vec;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  // Reference model: what the arbiter is doing right now.
  // 0 = free, 1 = asking the core, 2 = acknowledging, 3 = in handler
  int m_phase  = 0;
  int m_line   = 0;
  bit m_shadow = 0;
  int m_vec    = 0;

  function automatic int lowest(input logic [4:0] v);
    for (int i = 0; i < NL; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic void chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endfunction

  // Drive one cycle of inputs at the falling edge and queue the expectation
  // for the outputs after the following rising edge.
  task automatic step(input bit r, input bit e, input logic [4:0] lines, input bit i,
                      input bit bnd, input bit sei, input bit take);
    exp_t x;
    int   lw;
    @(negedge clk);
    rst               = r;
    ena               = e;
    bus.irq_lines     = lines;
    bus.i_flag        = i;
    bus.inst_boundary = bnd;
    bus.sei_exec      = sei;
    bus.irq_take      = take;
    if (r) begin
      m_phase  = 0;
      m_shadow = 0;
      m_vec    = 0;
      m_line   = 0;
    end else if (e) begin
      case (m_phase)
        0: begin
          lw = lowest(lines);
          if (bnd && i && !m_shadow && !sei && lw >= 0) begin
            m_line  = lw;
            m_vec   = (1 + lw) % 32;
            m_phase = 1;
          end
        end
        1: begin
          if (take) m_phase = 2;
          else if (!i || !lines[m_line]) m_phase = 0;
        end
        2: m_phase = 3;
        default: if (!i || sei) m_phase = 0;
      endcase
      if (sei) m_shadow = 1;
      else if (bnd) m_shadow = 0;
    end
    x.due     = cyc + 1;
    x.req     = (m_phase == 1);
    x.vec     = 5'(m_vec);
    x.ack     = (!r && e && m_phase == 2) ? 5'(1 << m_line) : 5'd0;
    x.pend    = (lines != 0) && i;
    x.chk_vec = x.req || r;
    q.push_back(x);
  endtask

  // Monitor: compare DUT outputs against each expectation as it falls due.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      while (q.size() > 0 && q[0].due <= cyc) begin
        x = q.pop_front();
        chk("irq_req", int'(bus.irq_req), int'(x.req));
        chk("irq_ack", int'(bus.irq_ack), int'(x.ack));
        chk("pending", int'(bus.pending), int'(x.pend));
        if (x.chk_vec) chk("irq_vector", int'(bus.irq_vector), int'(x.vec));
      end
    end
  end

  initial begin
    rst = 1'b1;
    ena = 1'b1;
    bus.irq_lines     = '0;
    bus.i_flag        = 1'b0;
    bus.inst_boundary = 1'b0;
    bus.sei_exec      = 1'b0;
    bus.irq_take      = 1'b0;

    // Reset, then reset while requesting; a later take must not ack.
    step(1, 1, 5'b00000, 0, 0, 0, 0);
    step(1, 1, 5'b00000, 0, 0, 0, 0);
    step(0, 1, 5'b00001, 1, 1, 0, 0);
    step(0, 1, 5'b00001, 1, 0, 0, 0);
    step(1, 1, 5'b00001, 1, 0, 0, 0);
    step(0, 1, 5'b00001, 1, 0, 0, 1);
    step(0, 1, 5'b00000, 0, 0, 0, 0);

    // Priority and vector hold, then take and handler exit.
    step(0, 1, 5'b10100, 1, 1, 0, 0);
    step(0, 1, 5'b10101, 1, 0, 0, 0);
    step(0, 1, 5'b10101, 1, 1, 0, 0);
    step(0, 1, 5'b10101, 1, 0, 0, 1);
    step(0, 1, 5'b10101, 1, 0, 0, 0);
    step(0, 1, 5'b10101, 1, 1, 0, 0);
    step(0, 1, 5'b00000, 0, 0, 0, 0);

    // SEI shadow: one instruction runs before the interrupt.
    step(0, 1, 5'b00010, 0, 1, 0, 0);
    step(0, 1, 5'b00010, 1, 0, 1, 0);
    step(0, 1, 5'b00010, 1, 1, 0, 0);
    step(0, 1, 5'b00010, 1, 0, 0, 0);
    step(0, 1, 5'b00010, 1, 1, 0, 0);
    step(0, 1, 5'b00010, 1, 0, 0, 1);
    step(0, 1, 5'b00010, 1, 0, 0, 0);
    step(0, 1, 5'b00000, 0, 0, 0, 0);
    // SEI coinciding with a boundary.
    step(0, 1, 5'b01000, 1, 1, 1, 0);
    step(0, 1, 5'b01000, 1, 1, 0, 0);
    step(0, 1, 5'b01000, 1, 1, 0, 0);
    step(0, 1, 5'b01000, 0, 0, 0, 0);

    // Cancel by line drop, by I drop, and take winning over cancel.
    step(0, 1, 5'b00100, 1, 1, 0, 0);
    step(0, 1, 5'b00000, 1, 0, 0, 0);
    step(0, 1, 5'b00100, 1, 1, 0, 0);
    step(0, 1, 5'b00100, 0, 0, 0, 0);
    step(0, 1, 5'b00100, 1, 1, 0, 0);
    step(0, 1, 5'b00000, 0, 0, 0, 1);
    step(0, 1, 5'b00000, 0, 0, 0, 0);
    step(0, 1, 5'b00000, 0, 0, 0, 0);

    // Same request/take sequence with the clock enable toggling.
    for (int k = 0; k < 14; k++) begin
      step(0, (k % 2) == 0, 5'b10100, (k < 10), (k < 2), 0, (k >= 4 && k < 6));
    end

    // Handler hold: no re-request until I drops and comes back.
    step(0, 1, 5'b00001, 1, 1, 0, 0);
    step(0, 1, 5'b00001, 1, 0, 0, 1);
    step(0, 1, 5'b00001, 1, 1, 0, 0);
    step(0, 1, 5'b00001, 1, 1, 0, 0);
    step(0, 1, 5'b00001, 1, 1, 0, 0);
    step(0, 1, 5'b00001, 0, 0, 0, 0);
    step(0, 1, 5'b00001, 1, 1, 0, 0);
    step(0, 1, 5'b00001, 1, 0, 0, 1);
    step(0, 1, 5'b00001, 1, 0, 0, 0);
    // RETI exits the handler with the shadow armed.
    step(0, 1, 5'b00001, 1, 0, 1, 0);
    step(0, 1, 5'b00001, 1, 1, 0, 0);
    step(0, 1, 5'b00001, 1, 1, 0, 0);
    step(0, 1, 5'b00000, 0, 0, 0, 0);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           5'($urandom) & 5'($urandom | $urandom),
           ($urandom_range(0, 5) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) == 0));
    end
    step(0, 1, 5'b00000, 0, 0, 0, 0);

    repeat (3) @(posedge clk);
    #3;
    chk("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
